// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time over valid/ready, fixed response latency.
// Stores commit and loads are captured at the accept edge; the response is held until taken.
module dmem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] MEM_BYTES = 64'(DEPTH_WORDS) * 64'd8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  count;
  logic [63:0] mem [DEPTH_WORDS];

  logic          accept;
  logic [2:0]    lane;
  logic [AW-1:0] word_idx;
  logic [63:0]   nbytes;
  logic [2:0]    align_mask;
  logic          misaligned;
  logic          out_of_range;
  logic          req_err;
  logic [7:0]    be_base;
  logic [7:0]    be;
  logic [63:0]   wdata_sh;
  logic [63:0]   rd_word;
  logic [63:0]   rd_mask;
  logic [63:0]   load_data;

  assign accept = req_valid && req_ready && (state == IDLE);

  // Decode the presented request: legality, byte lanes and the aligned load value.
  always_comb begin
    lane         = req_addr[2:0];
    word_idx     = req_addr[3 +: AW];
    nbytes       = 64'd1 << req_size;
    align_mask   = 3'b000;
    be_base      = 8'h00;
    rd_mask      = 64'd0;
    case (req_size)
      2'd0: begin align_mask = 3'b000; be_base = 8'h01; rd_mask = 64'h0000_0000_0000_00FF; end
      2'd1: begin align_mask = 3'b001; be_base = 8'h03; rd_mask = 64'h0000_0000_0000_FFFF; end
      2'd2: begin align_mask = 3'b011; be_base = 8'h0F; rd_mask = 64'h0000_0000_FFFF_FFFF; end
      default: begin align_mask = 3'b111; be_base = 8'hFF; rd_mask = 64'hFFFF_FFFF_FFFF_FFFF; end
    endcase
    misaligned   = |(lane & align_mask);
    // Full-width compare so high address bits can never alias into the array.
    out_of_range = req_addr > (MEM_BYTES - nbytes);
    req_err      = misaligned || out_of_range;
    be           = be_base << lane;
    wdata_sh     = req_wdata << {lane, 3'b000};
    rd_word      = mem[word_idx];
    load_data    = (rd_word >> {lane, 3'b000}) & rd_mask;
  end

  // Storage has no reset; only legal accepted stores touch it, byte by byte.
  always_ff @(posedge clk) begin
    if (accept && req_write && !req_err) begin
      for (int i = 0; i < 8; i++) begin
        if (be[i]) begin
          mem[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
        end
      end
    end
  end

  // Handshake FSM; the counter runs down so RESP is entered LATENCY edges after accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
      count      <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready  <= 1'b0;
            resp_err   <= req_err;
            resp_rdata <= (req_err || req_write) ? 64'd0 : load_data;
            if (LATENCY <= 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              count      <= 4'd0;
            end else begin
              state <= BUSY;
              count <= 4'(LATENCY - 1);
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        BUSY: begin
          count <= count - 4'd1;
          if (count <= 4'd1) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 4) checked against a byte-array
// model of the memory and the error rules, plus fixed directed scenarios.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int MEM_BYTES = 1024;

  logic        clk;
  logic        rst        [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [1:0]  req_size   [3];
  logic [63:0] req_addr   [3];
  logic [63:0] req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [63:0] resp_rdata [3];
  logic        resp_err   [3];

  int total;
  int bad;
  logic [7:0] model [3][MEM_BYTES];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(128),
      .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 4))
    ) u_dut (
      .clk       (clk),
      .reset     (rst[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_size  (req_size[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  // Reference: memory as a flat byte array, errors from the alignment and range rules.
  function automatic void model_access(input int k, input logic wr, input logic [1:0] sz,
                                       input logic [63:0] addr, input logic [63:0] wd,
                                       output logic [63:0] rd, output logic er);
    int n;
    n  = 1 << sz;
    rd = 64'd0;
    er = ((addr % 64'(n)) != 64'd0) || (addr > 64'(MEM_BYTES - n));
    if (!er) begin
      for (int b = 0; b < n; b++) begin
        if (wr) model[k][int'(addr) + b] = wd[8*b +: 8];
        else    rd[8*b +: 8] = model[k][int'(addr) + b];
      end
    end
  endfunction

  task automatic junk(input int k);
    req_valid[k] = 1'($urandom);
    req_write[k] = 1'($urandom);
    req_size[k]  = 2'($urandom);
    req_addr[k]  = 64'($urandom_range(0, MEM_BYTES - 1));
    req_wdata[k] = {$urandom, $urandom};
  endtask

  task automatic start_req(input int k, input logic wr, input logic [1:0] sz,
                           input logic [63:0] addr, input logic [63:0] wd, output bit ok);
    int w;
    w  = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!req_ready[k] && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready[k]) begin
      ok = 1'b0;
      return;
    end
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_size[k]  = sz;
    req_addr[k]  = addr;
    req_wdata[k] = wd;
    @(posedge clk);
    #1;
    junk(k);
  endtask

  task automatic finish_resp(input int k, output logic [63:0] rd, output logic er, output int lat);
    lat = 1;
    while (!resp_valid[k] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = resp_rdata[k];
    er = resp_err[k];
    if (!resp_valid[k]) lat = -1;
    req_valid[k]  = 1'b0;
    resp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[k] = 1'b0;
  endtask

  task automatic do_txn(input int k, input logic wr, input logic [1:0] sz, input logic [63:0] addr,
                        input logic [63:0] wd, output logic [63:0] rd, output logic er, output int lat);
    bit ok;
    start_req(k, wr, sz, addr, wd, ok);
    if (!ok) begin
      rd  = 64'd0;
      er  = 1'b0;
      lat = -2;
      return;
    end
    finish_resp(k, rd, er, lat);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0; req_valid[k] = 1'b0; resp_ready[k] = 1'b0; req_write[k] = 1'b0;
      req_size[k] = 2'd0; req_addr[k] = 64'd0; req_wdata[k] = 64'd0;
    end
    #12;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (req_ready[k] !== 1'b0 || resp_valid[k] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_hs k=%0d ready=%b valid=%b exp=0/0", k, req_ready[k], resp_valid[k]);
      end
      total++;
      if (resp_rdata[k] !== 64'd0 || resp_err[k] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_data k=%0d rdata=%h err=%b exp=0/0", k, resp_rdata[k], resp_err[k]);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (req_ready[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release_ready got=%b exp=1", req_ready[0]);
    end
  endtask

  task automatic init_mem(input int k);
    logic [63:0] d, rd, erm, rdd;
    logic er;
    int lat;
    for (int w = 0; w < MEM_BYTES / 8; w++) begin
      d = {$urandom, $urandom};
      model_access(k, 1'b1, 2'd3, 64'(w * 8), d, erm, er);
      do_txn(k, 1'b1, 2'd3, 64'(w * 8), d, rdd, er, lat);
    end
    rd = 64'd0;
    total++;
    if (lat !== lat_of(k)) begin
      bad++;
      $display("[TB] FAIL init_lat k=%0d got=%0d exp=%0d rd=%h", k, lat, lat_of(k), rd);
    end
  endtask

  task automatic test_load_basic();
    logic [63:0] rd, mrd;
    logic er, mer;
    int lat;
    model_access(0, 1'b1, 2'd3, 64'h100, 64'h1234567890ABCDEF, mrd, mer);
    do_txn(0, 1'b1, 2'd3, 64'h100, 64'h1234567890ABCDEF, rd, er, lat);
    do_txn(0, 1'b0, 2'd3, 64'h100, 64'd0, rd, er, lat);
    total++;
    if (lat !== 2) begin
      bad++;
      $display("[TB] FAIL load_basic_lat got=%0d exp=2", lat);
    end
    total++;
    if (rd !== 64'h1234567890ABCDEF || er !== 1'b0) begin
      bad++;
      $display("[TB] FAIL load_basic_data got=%h err=%b exp=1234567890abcdef err=0", rd, er);
    end
  endtask

  task automatic test_partial_store();
    logic [63:0] rd, mrd;
    logic er, mer;
    int lat;
    model_access(0, 1'b1, 2'd3, 64'h200, 64'hB, mrd, mer);
    do_txn(0, 1'b1, 2'd3, 64'h200, 64'hB, rd, er, lat);
    total++;
    if (rd !== 64'd0 || er !== 1'b0) begin
      bad++;
      $display("[TB] FAIL store_resp got=%h err=%b exp=0 err=0", rd, er);
    end
    model_access(0, 1'b1, 2'd0, 64'h203, 64'hAA, mrd, mer);
    do_txn(0, 1'b1, 2'd0, 64'h203, 64'hAA, rd, er, lat);
    do_txn(0, 1'b0, 2'd3, 64'h200, 64'd0, rd, er, lat);
    total++;
    if (rd !== 64'h00000000AA00000B) begin
      bad++;
      $display("[TB] FAIL partial_word got=%h exp=00000000aa00000b", rd);
    end
    do_txn(0, 1'b0, 2'd1, 64'h202, 64'd0, rd, er, lat);
    total++;
    if (rd !== 64'hAA00 || er !== 1'b0) begin
      bad++;
      $display("[TB] FAIL partial_half got=%h err=%b exp=aa00 err=0", rd, er);
    end
  endtask

  task automatic test_errors();
    logic [63:0] addrs [8];
    logic        wrs   [8];
    logic [1:0]  szs   [8];
    logic [63:0] rd, mrd, wd;
    logic er, mer;
    int lat;
    addrs = '{64'h102, 64'h400, 64'h3FF, 64'h3F8, 64'h3FF, 64'h3FC,
              64'hFFFF_FFFF_FFFF_FF00, 64'h8000_0000_0000_0100};
    wrs   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    szs   = '{2'd2, 2'd3, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0, 2'd3};
    for (int i = 0; i < 8; i++) begin
      wd = {$urandom, $urandom};
      model_access(0, wrs[i], szs[i], addrs[i], wd, mrd, mer);
      do_txn(0, wrs[i], szs[i], addrs[i], wd, rd, er, lat);
      total++;
      if (er !== mer || rd !== mrd) begin
        bad++;
        $display("[TB] FAIL err_case%0d got err=%b rd=%h exp err=%b rd=%h", i, er, rd, mer, mrd);
      end
    end
    for (int i = 0; i < 2; i++) begin
      model_access(0, 1'b0, 2'd3, (i == 0) ? 64'h0 : 64'h100, 64'd0, mrd, mer);
      do_txn(0, 1'b0, 2'd3, (i == 0) ? 64'h0 : 64'h100, 64'd0, rd, er, lat);
      total++;
      if (rd !== mrd) begin
        bad++;
        $display("[TB] FAIL err_unchanged%0d got=%h exp=%h", i, rd, mrd);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd, mrd, d;
    logic er, mer;
    int lat;
    bit ok;
    model_access(0, 1'b0, 2'd3, 64'h100, 64'd0, mrd, mer);
    start_req(0, 1'b0, 2'd3, 64'h100, 64'd0, ok);
    req_valid[0] = 1'b0;
    lat = 1;
    while (!resp_valid[0] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== mrd || resp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL hold_c%0d valid=%b rd=%h err=%b ready=%b exp 1/%h/0/0",
                 c, resp_valid[0], resp_rdata[0], resp_err[0], req_ready[0], mrd);
      end
    end
    d = {$urandom, $urandom};
    resp_ready[0] = 1'b1;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_size[0] = 2'd3;
    req_addr[0] = 64'h110; req_wdata[0] = d;
    @(posedge clk);
    #1;
    resp_ready[0] = 1'b0;
    total++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL release_idle valid=%b ready=%b exp 0/1", resp_valid[0], req_ready[0]);
    end
    @(posedge clk);
    #1;
    total++;
    if (req_ready[0] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_accept ready=%b exp=0", req_ready[0]);
    end
    model_access(0, 1'b1, 2'd3, 64'h110, d, mrd, mer);
    junk(0);
    finish_resp(0, rd, er, lat);
    total++;
    if (lat !== 2 || er !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_lat got=%0d err=%b exp 2/0", lat, er);
    end
    do_txn(0, 1'b0, 2'd3, 64'h110, 64'd0, rd, er, lat);
    total++;
    if (rd !== d) begin
      bad++;
      $display("[TB] FAIL b2b_data got=%h exp=%h", rd, d);
    end
  endtask

  task automatic test_reset_midflight();
    logic [63:0] rd, mrd, d;
    logic er, mer;
    int lat, seen;
    bit ok;
    d = {$urandom, $urandom};
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin
        model_access(2, 1'b1, 2'd3, 64'h308, d, mrd, mer);
        start_req(2, 1'b1, 2'd3, 64'h308, d, ok);
      end else begin
        start_req(2, 1'b0, 2'd3, 64'h308, 64'd0, ok);
      end
      req_valid[2] = 1'b0;
      @(posedge clk);
      #2;
      rst[2] = 1'b0;
      #1;
      total++;
      if (resp_valid[2] !== 1'b0 || req_ready[2] !== 1'b0 || resp_rdata[2] !== 64'd0) begin
        bad++;
        $display("[TB] FAIL midreset%0d valid=%b ready=%b rd=%h exp 0/0/0",
                 s, resp_valid[2], req_ready[2], resp_rdata[2]);
      end
      @(negedge clk);
      rst[2] = 1'b1;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
        @(posedge clk);
        #1;
        if (resp_valid[2]) seen++;
      end
      total++;
      if (seen !== 0) begin
        bad++;
        $display("[TB] FAIL midreset%0d_noresp valid_cycles=%0d exp=0", s, seen);
      end
    end
    do_txn(2, 1'b0, 2'd3, 64'h308, 64'd0, rd, er, lat);
    total++;
    if (rd !== d || lat !== 4) begin
      bad++;
      $display("[TB] FAIL midreset_commit got=%h lat=%0d exp=%h lat=4", rd, lat, d);
    end
  endtask

  task automatic test_sweep();
    logic [63:0] rd, mrd, addr, d;
    logic [1:0] sz;
    logic er, mer;
    int lat, n;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 20; i++) begin
        sz   = 2'($urandom);
        n    = 1 << sz;
        addr = 64'($urandom_range(0, MEM_BYTES / n - 1) * n);
        d    = {$urandom, $urandom};
        model_access(k, 1'b1, sz, addr, d, mrd, mer);
        do_txn(k, 1'b1, sz, addr, d, rd, er, lat);
        total++;
        if (lat !== lat_of(k) || er !== 1'b0) begin
          bad++;
          $display("[TB] FAIL sweep_st k=%0d i=%0d lat=%0d err=%b exp %0d/0", k, i, lat, er, lat_of(k));
        end
        model_access(k, 1'b0, sz, addr, 64'd0, mrd, mer);
        do_txn(k, 1'b0, sz, addr, 64'd0, rd, er, lat);
        total++;
        if (rd !== mrd || lat !== lat_of(k)) begin
          bad++;
          $display("[TB] FAIL sweep_ld k=%0d i=%0d got=%h lat=%0d exp=%h lat=%0d", k, i, rd, lat, mrd, lat_of(k));
        end
        model_access(k, 1'b0, 2'd3, addr & ~64'd7, 64'd0, mrd, mer);
        do_txn(k, 1'b0, 2'd3, addr & ~64'd7, 64'd0, rd, er, lat);
        total++;
        if (rd !== mrd) begin
          bad++;
          $display("[TB] FAIL sweep_word k=%0d i=%0d got=%h exp=%h", k, i, rd, mrd);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    for (int k = 0; k < 3; k++) init_mem(k);
    test_load_basic();
    test_partial_store();
    test_errors();
    test_back_to_back();
    test_reset_midflight();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule
